// File: rtl/sparc_alu_seq.sv
`default_nettype none
// ============================================================================
// Module   : sparc_alu_seq
// Brief    : Clocked SPARC integer ALU with icc, Y register and iterative
//            multiply/divide behind a start/ready/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module sparc_alu_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [5:0]       op3_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             done_o,
  output logic [WIDTH-1:0] out_o,
  output logic [WIDTH-1:0] y_out_o,
  output logic             n_o,
  output logic             z_o,
  output logic             v_o,
  output logic             c_o,
  output logic             div_zero_o,
  output logic             illegal_op_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_t;

  localparam logic [SHW-1:0]   c_iter_last = SHW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] c_smax      = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] c_smin      = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   out_q, out_d, y_q, y_d;
  logic [3:0]         icc_q, icc_d;          // {n, z, v, c}
  logic               done_q, done_d, dz_q, dz_d, ill_q, ill_d;
  logic               cc_q, cc_d, div_q, div_d, sgn_q, sgn_d;
  logic [WIDTH:0]     hi_q, hi_d;            // partial product / remainder
  logic [WIDTH-1:0]   lo_q, lo_d;            // multiplier / quotient shifter
  logic [WIDTH-1:0]   dvs_q, dvs_d;          // multiplicand / divisor
  logic               neg_q, neg_d, ovf_q, ovf_d;
  logic [SHW-1:0]     cnt_q, cnt_d;

  // Single-cycle datapath
  logic               w_cin;
  logic [WIDTH:0]     w_sum, w_dif;
  logic [WIDTH-1:0]   w_res;
  logic [1:0]         w_vc;
  logic               w_legal, w_multi, w_wr_out, w_wr_y, w_setcc;

  // Iterative datapath
  logic [WIDTH-1:0]   w_mag_a, w_mag_b;
  logic [2*WIDTH-1:0] w_dvd, w_dvd_mag, w_prod_mag, w_prod;
  logic [WIDTH:0]     w_madd, w_dsh, w_dsub;
  logic               w_dge, w_qovf;
  logic [WIDTH-1:0]   w_quo;

  assign w_cin = op3_i[3] & icc_q[0];
  assign w_sum = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, w_cin};
  assign w_dif = {1'b0, a_i} - {1'b0, b_i} - {{WIDTH{1'b0}}, w_cin};

  // While multi-cycle, lo_q holds operand A and dvs_q operand B until LOAD
  assign w_mag_a    = (sgn_q && lo_q[WIDTH-1])  ? -lo_q  : lo_q;
  assign w_mag_b    = (sgn_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
  assign w_dvd      = {y_q, lo_q};
  assign w_dvd_mag  = (sgn_q && y_q[WIDTH-1]) ? -w_dvd : w_dvd;
  assign w_madd     = hi_q + (lo_q[0] ? {1'b0, dvs_q} : '0);
  assign w_dsh      = {hi_q[WIDTH-1:0], lo_q[WIDTH-1]};
  assign w_dge      = (w_dsh >= {1'b0, dvs_q});
  assign w_dsub     = w_dsh - {1'b0, dvs_q};
  assign w_prod_mag = {hi_q[WIDTH-1:0], lo_q};
  assign w_prod     = neg_q ? -w_prod_mag : w_prod_mag;

  // Decode op3 and compute the single-cycle result and V/C candidates
  always_comb begin
    w_legal  = 1'b0;
    w_multi  = 1'b0;
    w_wr_out = 1'b0;
    w_wr_y   = 1'b0;
    w_setcc  = op3_i[4];
    w_res    = out_q;
    w_vc     = 2'b00;
    if (!op3_i[5]) begin
      w_legal  = 1'b1;
      w_wr_out = 1'b1;
      case (op3_i[3:0])
        4'b0000, 4'b1000: begin
          w_res = w_sum[WIDTH-1:0];
          w_vc  = {(a_i[WIDTH-1] == b_i[WIDTH-1]) && (w_sum[WIDTH-1] != a_i[WIDTH-1]),
                   w_sum[WIDTH]};
        end
        4'b0100, 4'b1100: begin
          w_res = w_dif[WIDTH-1:0];
          w_vc  = {(a_i[WIDTH-1] != b_i[WIDTH-1]) && (w_dif[WIDTH-1] != a_i[WIDTH-1]),
                   w_dif[WIDTH]};
        end
        4'b0001: w_res = a_i & b_i;
        4'b0101: w_res = a_i & ~b_i;
        4'b0010: w_res = a_i | b_i;
        4'b0110: w_res = a_i | ~b_i;
        4'b0011: w_res = a_i ^ b_i;
        4'b0111: w_res = ~(a_i ^ b_i);
        4'b1010, 4'b1011, 4'b1110, 4'b1111: begin
          w_multi  = 1'b1;
          w_wr_out = 1'b0;
        end
        default: begin
          w_legal  = 1'b0;
          w_wr_out = 1'b0;
        end
      endcase
    end else begin
      w_setcc = 1'b0;
      case (op3_i)
        6'b100101: begin w_legal = 1'b1; w_wr_out = 1'b1; w_res = a_i << b_i[SHW-1:0]; end
        6'b100110: begin w_legal = 1'b1; w_wr_out = 1'b1; w_res = a_i >> b_i[SHW-1:0]; end
        6'b100111: begin w_legal = 1'b1; w_wr_out = 1'b1; w_res = $signed(a_i) >>> b_i[SHW-1:0]; end
        6'b101000: begin w_legal = 1'b1; w_wr_out = 1'b1; w_res = y_q; end
        6'b110000: begin w_legal = 1'b1; w_wr_y = 1'b1; end
        default:   ;
      endcase
    end
  end

  // Final quotient: sign correction and saturation on overflow
  always_comb begin
    w_qovf = ovf_q;
    w_quo  = lo_q;
    if (ovf_q) begin
      w_quo = !sgn_q ? {WIDTH{1'b1}} : (neg_q ? c_smin : c_smax);
    end else if (sgn_q) begin
      if (neg_q) begin
        if (lo_q[WIDTH-1] && (|lo_q[WIDTH-2:0])) begin
          w_qovf = 1'b1;
          w_quo  = c_smin;
        end else begin
          w_quo = -lo_q;
        end
      end else if (lo_q[WIDTH-1]) begin
        w_qovf = 1'b1;
        w_quo  = c_smax;
      end
    end
  end

  // Next-state logic for the control FSM and all architectural registers
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    y_d     = y_q;
    icc_d   = icc_q;
    done_d  = 1'b0;
    dz_d    = 1'b0;
    ill_d   = 1'b0;
    cc_d    = cc_q;
    div_d   = div_q;
    sgn_d   = sgn_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    dvs_d   = dvs_q;
    neg_d   = neg_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          if (!w_legal) begin
            done_d = 1'b1;
            ill_d  = 1'b1;
          end else if (w_multi) begin
            cc_d    = op3_i[4];
            div_d   = op3_i[2];
            sgn_d   = op3_i[0];
            lo_d    = a_i;
            dvs_d   = b_i;
            state_d = S_LOAD;
          end else begin
            done_d = 1'b1;
            if (w_wr_out) out_d = w_res;
            if (w_wr_y)   y_d   = a_i ^ b_i;
            if (w_wr_out && w_setcc) icc_d = {w_res[WIDTH-1], (w_res == '0), w_vc};
          end
        end
      end
      S_LOAD: begin
        cnt_d = c_iter_last;
        if (!div_q) begin
          hi_d    = '0;
          lo_d    = w_mag_a;
          dvs_d   = w_mag_b;
          neg_d   = sgn_q & (lo_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          state_d = S_ITER;
        end else if (dvs_q == '0) begin
          done_d  = 1'b1;
          dz_d    = 1'b1;
          state_d = S_IDLE;
        end else begin
          hi_d  = {1'b0, w_dvd_mag[2*WIDTH-1:WIDTH]};
          lo_d  = w_dvd_mag[WIDTH-1:0];
          dvs_d = w_mag_b;
          neg_d = sgn_q & (y_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
          // A high half at or above the divisor cannot yield a WIDTH-bit quotient
          if (w_dvd_mag[2*WIDTH-1:WIDTH] >= w_mag_b) begin
            ovf_d   = 1'b1;
            state_d = S_FIX;
          end else begin
            ovf_d   = 1'b0;
            state_d = S_ITER;
          end
        end
      end
      S_ITER: begin
        if (!div_q) begin
          hi_d = {1'b0, w_madd[WIDTH:1]};
          lo_d = {w_madd[0], lo_q[WIDTH-1:1]};
        end else begin
          hi_d = w_dge ? w_dsub : w_dsh;
          lo_d = {lo_q[WIDTH-2:0], w_dge};
        end
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - SHW'(1);
      end
      S_FIX: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
        if (!div_q) begin
          y_d   = w_prod[2*WIDTH-1:WIDTH];
          out_d = w_prod[WIDTH-1:0];
          if (cc_q) icc_d = {w_prod[WIDTH-1], (w_prod[WIDTH-1:0] == '0), 2'b00};
        end else begin
          out_d = w_quo;
          if (cc_q) icc_d = {w_quo[WIDTH-1], (w_quo == '0), w_qovf, 1'b0};
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      y_q     <= '0;
      icc_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      ill_q   <= 1'b0;
      cc_q    <= 1'b0;
      div_q   <= 1'b0;
      sgn_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      neg_q   <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      y_q     <= y_d;
      icc_q   <= icc_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      ill_q   <= ill_d;
      cc_q    <= cc_d;
      div_q   <= div_d;
      sgn_q   <= sgn_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      dvs_q   <= dvs_d;
      neg_q   <= neg_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o      = (state_q == S_IDLE);
  assign done_o       = done_q;
  assign out_o        = out_q;
  assign y_out_o      = y_q;
  assign {n_o, z_o, v_o, c_o} = icc_q;
  assign div_zero_o   = dz_q;
  assign illegal_op_o = ill_q;

endmodule
`default_nettype wire
